// File: rtl/filt_pkg.sv
// Shared constants and lane helper for the LP filter output serializer.
package filt_pkg;

  localparam int unsigned LANE_W = 16;
  localparam int unsigned LANES  = 6;
  localparam int unsigned WORD_W = LANE_W * LANES;
  localparam int unsigned IDX_W  = 3;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  function automatic logic [LANE_W-1:0] lane_sel(input logic [WORD_W-1:0] word,
                                                 input logic [IDX_W-1:0]  idx);
    logic [WORD_W-1:0] sh;
    sh = word >> (LANE_W * 32'(idx));
    return sh[LANE_W-1:0];
  endfunction

endpackage

// File: rtl/filt_word_fifo.sv
// DEPTH x 96-bit word FIFO; exposes the post-edge head word so the caller can register its output.
module filt_word_fifo
  import filt_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WORD_W-1:0]        wr_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty_nxt,
  output logic [WORD_W-1:0]        head_nxt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  rd_nxt;
  logic [LVL_W-1:0]  remain;
  logic [LVL_W-1:0]  level_nxt;

  assign full = (level == LVL_W'(DEPTH));

  always_comb begin
    rd_nxt    = pop ? rd_ptr + 1'b1 : rd_ptr;
    remain    = level - LVL_W'(pop);
    level_nxt = remain + LVL_W'(push);
    empty_nxt = (level_nxt == '0);
    // A push into a FIFO that empties this cycle becomes the new head directly.
    head_nxt  = (push && remain == '0) ? wr_data : mem[rd_nxt];
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      rd_ptr <= rd_nxt;
      level  <= level_nxt;
    end
  end

endmodule

// File: rtl/filt_serializer.sv
// Buffers 96-bit filter words and streams them as six 16-bit lanes with valid/ready.
// Optional FILT_SER_STATS_EN adds saturating word_cnt/drop_cnt counters.
module filt_serializer
  import filt_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [WORD_W-1:0]       in_data,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [LANE_W-1:0]       out_data,
  output logic                    out_last,
  output logic                    ovf,
  input  logic                    ovf_clr,
  output logic [$clog2(DEPTH):0]  level
`ifdef FILT_SER_STATS_EN
  ,
  output logic [31:0]             word_cnt,
  output logic [15:0]             drop_cnt
`endif
);

  logic              full;
  logic              empty_nxt;
  logic [WORD_W-1:0] head_nxt;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_nxt;
  logic              xfer;
  logic              retire;
  logic              push_acc;
  logic              drop;

  filt_word_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_acc),
    .pop       (retire),
    .wr_data   (in_data),
    .level     (level),
    .full      (full),
    .empty_nxt (empty_nxt),
    .head_nxt  (head_nxt)
  );

  always_comb begin
    xfer     = out_valid && out_ready;
    retire   = xfer && out_last;
    push_acc = in_valid && (!full || retire);
    drop     = in_valid && full && !retire;
    idx_nxt  = idx;
    if (xfer) begin
      idx_nxt = retire ? '0 : idx + 1'b1;
    end
  end

  // Outputs are registered from post-edge state so lane 0 appears the cycle after a push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      idx       <= idx_nxt;
      out_valid <= !empty_nxt;
      out_data  <= empty_nxt ? '0 : lane_sel(head_nxt, idx_nxt);
      out_last  <= !empty_nxt && (idx_nxt == LAST_IDX);
      if (drop) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

`ifdef FILT_SER_STATS_EN
  logic [31:0] word_base;
  logic [15:0] drop_base;

  // ovf_clr restarts from zero but still counts an event in the same cycle.
  always_comb begin
    word_base = ovf_clr ? '0 : word_cnt;
    drop_base = ovf_clr ? '0 : drop_cnt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      word_cnt <= (retire && word_base != '1) ? word_base + 1'b1 : word_base;
      drop_cnt <= (drop && drop_base != '1) ? drop_base + 1'b1 : drop_base;
    end
  end
`endif

endmodule

// File: tb/tb_filt_serializer.sv
// Randomized and directed bench for filt_serializer against a queue-based word/lane model.
module tb_filt_serializer;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [95:0] in_data;
  logic        out_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_last;
  logic        ovf;
  logic        ovf_clr;
  logic [2:0]  level;
`ifdef FILT_SER_STATS_EN
  logic [31:0] word_cnt;
  logic [15:0] drop_cnt;
`endif

  filt_serializer #(
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr),
    .level     (level)
`ifdef FILT_SER_STATS_EN
    ,
    .word_cnt  (word_cnt),
    .drop_cnt  (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [95:0] q[$];
  int          mi;
  bit          movf;
  int unsigned mwc;
  int unsigned mdc;
  int unsigned nasrt = 0;
  int unsigned nfail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nasrt++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mi   = 0;
    movf = 1'b0;
    mwc  = 0;
    mdc  = 0;
  endtask

  task automatic check_outputs();
    logic [95:0] w;
    logic [15:0] exp_d;
    bit          exp_v;
    exp_v = (q.size() > 0);
    exp_d = '0;
    if (exp_v) begin
      w     = q[0];
      exp_d = w[mi*16 +: 16];
    end
    chk("out_valid", 32'(out_valid), 32'(exp_v));
    chk("out_data",  32'(out_data),  32'(exp_d));
    chk("out_last",  32'(out_last),  32'(exp_v && mi == 5));
    chk("level",     32'(level),     32'(q.size()));
    chk("ovf",       32'(ovf),       32'(movf));
`ifdef FILT_SER_STATS_EN
    chk("word_cnt",  word_cnt,       mwc);
    chk("drop_cnt",  32'(drop_cnt),  mdc);
`endif
  endtask

  // Check current outputs, then drive one cycle of stimulus and advance the model.
  task automatic step(input bit iv, input logic [95:0] d, input bit rdy, input bit clr);
    bit xf, ret, acc, drp;
    @(negedge clk);
    check_outputs();
    in_valid  = iv;
    in_data   = d;
    out_ready = rdy;
    ovf_clr   = clr;
    xf  = (q.size() > 0) && rdy;
    ret = xf && (mi == 5);
    acc = iv && ((q.size() < DEPTH) || ret);
    drp = iv && !acc;
    if (xf) mi = ret ? 0 : mi + 1;
    if (clr) begin
      mwc = 0;
      mdc = 0;
    end
    if (ret) begin
      void'(q.pop_front());
      if (mwc != 32'hFFFF_FFFF) mwc++;
    end
    if (acc) q.push_back(d);
    if (drp && mdc != 16'hFFFF) mdc++;
    if (drp) movf = 1'b1;
    else if (clr) movf = 1'b0;
  endtask

  function automatic logic [95:0] rnd96();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    ovf_clr   = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(negedge clk);
    rst = 1'b1;

    // Single word, lanes 1..6 with ready held high
    step(1'b1, 96'h0006_0005_0004_0003_0002_0001, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Backpressure: ready toggles while lanes are presented
    step(1'b1, rnd96(), 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) step(1'b0, '0, (i % 2) == 0, 1'b0);

    // Overflow: five pushes with no drain, then clear and drain
    for (int i = 0; i < 5; i++) step(1'b1, rnd96(), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 26; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Full with retire: push lands on the lane-5 transfer cycle
    for (int i = 0; i < 4; i++) step(1'b1, rnd96(), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, rnd96(), 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("full_retire_level", 32'(level), 32'd4);
    chk("full_retire_ovf",   32'(ovf),   32'd0);
    for (int i = 0; i < 26; i++) step(1'b0, '0, 1'b1, 1'b0);

`ifdef FILT_SER_STATS_EN
    // Stats: three retired, two dropped, then clear
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, rnd96(), 1'b0, 1'b0);
    for (int i = 0; i < 18; i++) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("stats_word_cnt", word_cnt, 32'd3);
    chk("stats_drop_cnt", 32'(drop_cnt), 32'd2);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("stats_word_clr", word_cnt, 32'd0);
    chk("stats_drop_clr", 32'(drop_cnt), 32'd0);
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0);
`endif

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) == 0, rnd96(), $urandom_range(0, 3) != 0,
           $urandom_range(0, 31) == 0);
    end

    // Reset mid-stream with a word in flight and ovf set
    for (int i = 0; i < 5; i++) step(1'b1, rnd96(), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("pre_reset_valid", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_reset_valid", 32'(out_valid), 32'd0);
    chk("async_reset_level", 32'(level),     32'd0);
    chk("async_reset_ovf",   32'(ovf),       32'd0);
    chk("async_reset_data",  32'(out_data),  32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, rnd96(), 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nasrt, nfail);
    $finish;
  end

endmodule
